// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between NUM_REQ requesters.
// Round-robin arbitration, SETUP/ACCESS sequencing, PREADY wait states and an
// optional wait-state timeout that aborts a stalled transfer with an error.
module apb_master_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      timeout_evt,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    last_winner_r, owner_r, winner_s, cand_s;
  logic                found_s, timeout_s, complete_s, arb_pt_s, grant_s;
  logic [CNT_W-1:0]    wait_cnt_r;
  logic [ADDR_W-1:0]   paddr_r;
  logic [DATA_W-1:0]   pwdata_r, rsp_rdata_r;
  logic                psel_r, penable_r, pwrite_r, rsp_err_r, timeout_evt_r;
  logic [NUM_REQ-1:0]  rsp_valid_r;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Abort detection: last allowed stalled ACCESS cycle with pready still low.
  always_comb begin
    timeout_s = 1'b0;
    if (TIMEOUT_CYC > 0) begin
      timeout_s = (state_r == ST_ACCESS) && !pready && (wait_cnt_r == CNT_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // A transfer completes on pready or abort; arbitration happens when idle or completing.
  always_comb begin
    complete_s = (state_r == ST_ACCESS) && (pready || timeout_s);
    arb_pt_s   = !preset && ((state_r == ST_IDLE) || complete_s);
    grant_s    = arb_pt_s && found_s;
  end

  // Round-robin search upward from the requester after the last winner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = {IDX_W{1'b0}};
    cand_s   = {IDX_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDX_W'((int'(last_winner_r) + k) % NUM_REQ);
      if (!found_s && req_valid[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Combinational one-hot grant to the winner at an arbitration point.
  always_comb begin
    req_gnt = {NUM_REQ{1'b0}};
    if (grant_s) begin
      req_gnt = onehot(winner_s);
    end else begin
      req_gnt = {NUM_REQ{1'b0}};
    end
  end

  // Next-state logic for the APB phase sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) state_s = ST_SETUP;
        else         state_s = ST_IDLE;
      end
      ST_SETUP: state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (complete_s) state_s = grant_s ? ST_SETUP : ST_IDLE;
        else            state_s = ST_ACCESS;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, APB bus registers, arbitration pointer and wait counter.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r       <= ST_IDLE;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_W{1'b0}};
      pwdata_r      <= {DATA_W{1'b0}};
      owner_r       <= {IDX_W{1'b0}};
      last_winner_r <= IDX_W'(NUM_REQ - 1);
      wait_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      psel_r    <= (state_s != ST_IDLE);
      penable_r <= (state_s == ST_ACCESS);
      if (grant_s) begin
        paddr_r       <= req_addr[winner_s*ADDR_W +: ADDR_W];
        pwdata_r      <= req_wdata[winner_s*DATA_W +: DATA_W];
        pwrite_r      <= req_write[winner_s];
        owner_r       <= winner_s;
        last_winner_r <= winner_s;
      end
      if (state_s == ST_SETUP) begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_ACCESS) && !pready && (wait_cnt_r != CNT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end
    end
  end

  // Completion response and abort pulse, one cycle after the completing ACCESS.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_valid_r   <= {NUM_REQ{1'b0}};
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      timeout_evt_r <= 1'b0;
    end else begin
      timeout_evt_r <= timeout_s;
      if (complete_s) begin
        rsp_valid_r <= onehot(owner_r);
        rsp_rdata_r <= (pready && !pwrite_r) ? prdata : {DATA_W{1'b0}};
        rsp_err_r   <= pready ? pslverr : 1'b1;
      end else begin
        rsp_valid_r <= {NUM_REQ{1'b0}};
      end
    end
  end

  assign paddr       = paddr_r;
  assign pwdata      = pwdata_r;
  assign pwrite      = pwrite_r;
  assign psel        = psel_r;
  assign penable     = penable_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign timeout_evt = timeout_evt_r;

endmodule
